// File: rtl/int_arbiter.sv
// Round-robin interrupt arbiter feeding the fetch stage's single interrupt input.
// Issues one ipu_int per grant, waits for int_ack, then blocks new grants until int_ret.
module int_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_req,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic               hold,
    input  logic               int_ack,
    input  logic               int_ret,
    output logic               ipu_int,
    output logic [2:0]         irq_id,
    output logic [NUM_SRC-1:0] irq_clr,
    output logic               busy,
    output logic               timeout_err
);

    localparam int TMO_W = (ACK_TIMEOUT > 15) ? $clog2(ACK_TIMEOUT + 1) : 4;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, IN_SVC} state_t;

    state_t             state, state_nxt;
    logic [2:0]         rr_ptr, rr_ptr_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;
    logic               ipu_int_nxt, busy_nxt, timeout_err_nxt;
    logic [2:0]         irq_id_nxt;
    logic [NUM_SRC-1:0] irq_clr_nxt;

    logic [7:0]         pend8;
    logic [7:0]         clr8;
    logic [3:0]         idx;
    logic [2:0]         winner;
    logic [2:0]         id_inc;
    logic               found;

    assign pend8  = 8'(irq_req & irq_en);
    assign clr8   = 8'b1 << irq_id;
    assign id_inc = (irq_id == 3'(NUM_SRC - 1)) ? 3'd0 : irq_id + 3'd1;

    // Search upward from rr_ptr, wrapping at NUM_SRC rather than at 8.
    always_comb begin
        winner = 3'd0;
        found  = 1'b0;
        idx    = 4'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = {1'b0, rr_ptr} + 4'(i);
            if (idx >= 4'(NUM_SRC)) idx = idx - 4'(NUM_SRC);
            if (!found && pend8[idx[2:0]]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        rr_ptr_nxt      = rr_ptr;
        tmo_cnt_nxt     = tmo_cnt;
        ipu_int_nxt     = 1'b0;
        irq_id_nxt      = irq_id;
        irq_clr_nxt     = '0;
        busy_nxt        = busy;
        timeout_err_nxt = timeout_err;
        case (state)
            IDLE: begin
                if (found && !hold) begin
                    state_nxt   = WAIT_ACK;
                    ipu_int_nxt = 1'b1;
                    irq_id_nxt  = winner;
                    tmo_cnt_nxt = '0;
                    busy_nxt    = 1'b1;
                end
            end
            WAIT_ACK: begin
                // An ack arriving on the timeout cycle still completes the grant.
                if (int_ack) begin
                    state_nxt   = IN_SVC;
                    irq_clr_nxt = clr8[NUM_SRC-1:0];
                    rr_ptr_nxt  = id_inc;
                end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT)) begin
                    state_nxt       = IDLE;
                    timeout_err_nxt = 1'b1;
                    rr_ptr_nxt      = id_inc;
                    busy_nxt        = 1'b0;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
            end
            IN_SVC: begin
                if (int_ret) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 3'd0;
            tmo_cnt     <= '0;
            ipu_int     <= 1'b0;
            irq_id      <= 3'd0;
            irq_clr     <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            ipu_int     <= ipu_int_nxt;
            irq_id      <= irq_id_nxt;
            irq_clr     <= irq_clr_nxt;
            busy        <= busy_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: directed vector table, timeout and async-reset sequences,
// then randomized traffic against a behavioural model.
module tb_int_arbiter;

    localparam int N   = 4;
    localparam int TMO = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq_req, irq_en, irq_clr;
    logic         hold, int_ack, int_ret;
    logic         ipu_int, busy, timeout_err;
    logic [2:0]   irq_id;

    int checks = 0;
    int errors = 0;

    int_arbiter #(.NUM_SRC(N), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .irq_req(irq_req), .irq_en(irq_en), .hold(hold),
        .int_ack(int_ack), .int_ret(int_ret), .ipu_int(ipu_int), .irq_id(irq_id),
        .irq_clr(irq_clr), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 = idle, 1 = awaiting ack, 2 = in handler.
    int           m_phase, m_next, m_waited, m_id;
    logic         m_ipu, m_busy, m_err;
    logic [N-1:0] m_clr;

    task automatic model_reset();
        m_phase = 0; m_next = 0; m_waited = 0; m_id = 0;
        m_ipu = 0; m_busy = 0; m_err = 0; m_clr = '0;
    endtask

    task automatic model_edge();
        logic [N-1:0] pend;
        int pick;
        pend  = irq_req & irq_en;
        m_ipu = 0;
        m_clr = '0;
        if (m_phase == 0) begin
            pick = -1;
            for (int k = N - 1; k >= 0; k--)
                if (pend[(m_next + k) % N]) pick = (m_next + k) % N;
            if (pick >= 0 && !hold) begin
                m_phase = 1; m_ipu = 1; m_id = pick; m_waited = 0; m_busy = 1;
            end
        end else if (m_phase == 1) begin
            if (int_ack) begin
                m_phase = 2; m_clr = N'(1) << m_id; m_next = (m_id + 1) % N;
            end else if (m_waited == TMO) begin
                m_phase = 0; m_err = 1; m_next = (m_id + 1) % N; m_busy = 0;
            end else begin
                m_waited++;
            end
        end else if (int_ret) begin
            m_phase = 0; m_busy = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit cmp_model);
        @(posedge clk);
        model_edge();
        #1;
        if (cmp_model) begin
            chk("model_ipu_int", 32'(ipu_int), 32'(m_ipu));
            chk("model_irq_id", 32'(irq_id), 32'(m_id));
            chk("model_irq_clr", 32'(irq_clr), 32'(m_clr));
            chk("model_busy", 32'(busy), 32'(m_busy));
            chk("model_timeout_err", 32'(timeout_err), 32'(m_err));
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ipu_int"}, 32'(ipu_int), 0);
        chk({name, "_irq_id"}, 32'(irq_id), 0);
        chk({name, "_irq_clr"}, 32'(irq_clr), 0);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_timeout_err"}, 32'(timeout_err), 0);
    endtask

    typedef struct {
        logic [N-1:0] req, en;
        logic         hold, ack, ret;
        logic         ipu;
        logic [2:0]   id;
        logic [N-1:0] clr;
        logic         busy;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int n;
        bit clr_seen;

        tbl[0]  = '{4'h1, 4'hF, 0, 0, 0, 1, 3'd0, 4'h0, 1};
        tbl[1]  = '{4'h1, 4'hF, 0, 0, 0, 0, 3'd0, 4'h0, 1};
        tbl[2]  = '{4'h1, 4'hF, 0, 1, 0, 0, 3'd0, 4'h1, 1};
        tbl[3]  = '{4'h0, 4'hF, 0, 0, 0, 0, 3'd0, 4'h0, 1};
        tbl[4]  = '{4'h0, 4'hF, 0, 1, 0, 0, 3'd0, 4'h0, 1};
        tbl[5]  = '{4'h0, 4'hF, 0, 0, 1, 0, 3'd0, 4'h0, 0};
        tbl[6]  = '{4'h0, 4'hF, 0, 0, 1, 0, 3'd0, 4'h0, 0};
        tbl[7]  = '{4'h4, 4'hB, 0, 0, 0, 0, 3'd0, 4'h0, 0};
        tbl[8]  = '{4'h4, 4'hB, 0, 0, 0, 0, 3'd0, 4'h0, 0};
        tbl[9]  = '{4'h4, 4'hF, 1, 0, 0, 0, 3'd0, 4'h0, 0};
        tbl[10] = '{4'h4, 4'hF, 1, 0, 0, 0, 3'd0, 4'h0, 0};
        tbl[11] = '{4'h4, 4'hF, 0, 0, 0, 1, 3'd2, 4'h0, 1};
        tbl[12] = '{4'h4, 4'hF, 0, 0, 0, 0, 3'd2, 4'h0, 1};
        tbl[13] = '{4'h0, 4'hF, 0, 1, 0, 0, 3'd2, 4'h4, 1};
        tbl[14] = '{4'hB, 4'hF, 0, 0, 0, 0, 3'd2, 4'h0, 1};
        tbl[15] = '{4'hB, 4'hF, 0, 0, 1, 0, 3'd2, 4'h0, 0};
        tbl[16] = '{4'hB, 4'hF, 0, 0, 0, 1, 3'd3, 4'h0, 1};
        tbl[17] = '{4'hB, 4'hF, 0, 1, 0, 0, 3'd3, 4'h8, 1};
        tbl[18] = '{4'hB, 4'hF, 0, 0, 1, 0, 3'd3, 4'h0, 0};
        tbl[19] = '{4'hB, 4'hF, 0, 0, 0, 1, 3'd0, 4'h0, 1};

        rst = 1; irq_req = '0; irq_en = '0; hold = 0; int_ack = 0; int_ret = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 0;

        foreach (tbl[i]) begin
            irq_req = tbl[i].req; irq_en = tbl[i].en; hold = tbl[i].hold;
            int_ack = tbl[i].ack; int_ret = tbl[i].ret;
            step(0);
            chk($sformatf("vec%0d_ipu_int", i), 32'(ipu_int), 32'(tbl[i].ipu));
            chk($sformatf("vec%0d_irq_id", i), 32'(irq_id), 32'(tbl[i].id));
            chk($sformatf("vec%0d_irq_clr", i), 32'(irq_clr), 32'(tbl[i].clr));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_timeout_err", i), 32'(timeout_err), 0);
        end

        // Granted source 0 is never acked: abandon after counter reaches 15.
        irq_req = 4'hB; int_ack = 0; int_ret = 0;
        n = 0;
        clr_seen = 0;
        while (busy && n < 40) begin
            step(1);
            n++;
            if (irq_clr != 0) clr_seen = 1;
        end
        chk("timeout_cycles", 32'(n), 16);
        chk("timeout_err_set", 32'(timeout_err), 1);
        chk("timeout_no_clr", 32'(clr_seen), 0);
        step(1);
        chk("reissue_ipu_int", 32'(ipu_int), 1);
        chk("reissue_irq_id", 32'(irq_id), 1);
        chk("timeout_err_sticky", 32'(timeout_err), 1);

        // Async reset inside WAIT_ACK, no clock edge in between.
        #2 rst = 1;
        #1;
        chk_all_zero("rst_wait");
        model_reset();
        rst = 0;
        step(1);
        chk("rearb_irq_id", 32'(irq_id), 0);
        chk("rearb_ipu_int", 32'(ipu_int), 1);
        int_ack = 1;
        step(1);
        int_ack = 0;
        step(1);
        chk("svc_busy", 32'(busy), 1);
        // Async reset inside IN_SVC.
        #2 rst = 1;
        #1;
        chk_all_zero("rst_svc");
        model_reset();
        rst = 0;
        irq_req = '0;
        step(1);

        for (int c = 0; c < 600; c++) begin
            irq_req = N'($urandom);
            irq_en  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            hold    = ($urandom_range(0, 4) == 0);
            int_ack = ($urandom_range(0, 9) < 4);
            int_ret = ($urandom_range(0, 4) == 0);
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
